inst_axi_rd_bridge: RTL and testbench
=====================================

# inst_axi_rd_bridge

Instruction-side responder for the fetch stage's SRAM-like request handshake (`inst_req` / `inst_addr_ok` / `inst_data_ok`). Accepts one fetch address at a time, issues a single-beat AXI4 read, and returns the fetched word to the fetch stage. Sits between the fetch stage and the AXI crossbar, and is the only AXI read master for instruction traffic.

## Interface
Parameters:
- `AXI_ID`, 4'd0, constant driven on `arid`
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (one instruction word)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `cpu_clk_50M`, in, 1, clock.
  - `cpu_rst_n`, in, 1, asynchronous active-low reset.
- Fetch-stage side:
  - `inst_req`, in, 1, fetch request.
  - `inst_addr`, in, ADDR_W, physical fetch address, sampled when the request is accepted.
  - `inst_cancel`, in, 1, flush: discard the outstanding fetch.
  - `inst_addr_ok`, out, 1, request accepted this cycle.
  - `inst_data_ok`, out, 1, one-cycle pulse: `inst_rdata` is valid.
  - `inst_rdata`, out, DATA_W, fetched word; holds its value until the next `inst_data_ok`.
  - `inst_bus_err`, out, 1, asserted together with `inst_data_ok` when `rresp` != OKAY.
- AXI read address channel:
  - `arid`, out, 4.
  - `araddr`, out, ADDR_W.
  - `arlen`, out, 8; constant 0.
  - `arsize`, out, 3; constant 3'b010.
  - `arburst`, out, 2; constant INCR (2'b01).
  - `arvalid`, out, 1.
  - `arready`, in, 1.
- AXI read data channel:
  - `rid`, in, 4.
  - `rdata`, in, DATA_W.
  - `rresp`, in, 2.
  - `rlast`, in, 1.
  - `rvalid`, in, 1.
  - `rready`, out, 1.

## Operation
- FSM states:
  - IDLE: `inst_addr_ok` = `inst_req` (combinational). On `inst_req`, latch `inst_addr`, go to AR.
  - AR: `arvalid` = 1, `araddr` = latched address. On `arready`, go to R.
  - R: `rready` = 1. On `rvalid`:
    - latch `rdata` into `inst_rdata`;
    - latch `rresp` != 2'b00 into the error flag;
    - go to IDLE;
    - register a one-cycle `inst_data_ok` (and `inst_bus_err`) pulse, unless the transaction is cancelled.
- At most one outstanding transaction. `inst_addr_ok` is 0 in AR and R, and in the cycle `inst_data_ok` is high. A new request is accepted only in IDLE.
- `rid` and `rlast` are not checked: single outstanding, single beat. The R phase ends on any `rvalid`.
- Cancel:
  - `inst_cancel` in AR or R sets a sticky `cancelled` flag.
  - The AXI transaction completes normally; AR is never withdrawn once asserted.
  - The matching `inst_data_ok` / `inst_bus_err` are suppressed, `inst_rdata` is not updated, and the flag clears on return to IDLE.
  - `inst_cancel` in the same cycle as acceptance marks that request cancelled.
  - `inst_cancel` in IDLE without a request has no effect.
- Error response:
  - `inst_rdata` still takes `rdata`.
  - `inst_bus_err` pulses with `inst_data_ok`.
  - The fetch stage converts the error into an exception; this block does not retry.

## Timing
- Reset values:
  - state = IDLE;
  - `arvalid`, `rready`, `inst_data_ok`, `inst_bus_err`, `cancelled` = 0;
  - `inst_rdata` = 0, latched address = 0;
  - `inst_addr_ok` = 0 while `cpu_rst_n` = 0.
- Reset asserted mid-transaction clears everything immediately (asynchronous), and `arvalid` drops in the same cycle. The AXI slave is reset by the same `cpu_rst_n`.
- Latency, with acceptance at cycle T and `arready`/`rvalid` at the earliest possible cycles:
  - `arvalid` high from T+1;
  - R entered at T+2;
  - `rvalid` at T+2 gives `inst_data_ok` at T+3.
  - Minimum request-to-data is 3 cycles; each AXI stall adds one cycle.
- Back-to-back: the earliest next `inst_addr_ok` is T+4, the cycle after the `inst_data_ok` pulse.
- `arvalid` stays high and `araddr` stays stable until `arready`, per AXI rules.
- `inst_req` deasserted before acceptance: nothing is issued.

## Structure
- Put in `defines.v`:
  - FSM state encodings `IRD_IDLE`, `IRD_AR`, `IRD_R`;
  - AXI constants `AXI_SIZE_4B`, `AXI_BURST_INCR`, `AXI_RESP_OKAY`.
- Single flat module, no sub-module.

## Test plan
- Fetch 0xBFC00000, `arready` and `rvalid` immediate, `rdata` = 0x3C080001: `inst_addr_ok` at T, `araddr` = 0xBFC00000 at T+1, `inst_data_ok` with `inst_rdata` = 0x3C080001 at T+3, `inst_bus_err` = 0.
- `arready` delayed 4 cycles, then `rvalid` delayed 2 cycles: `arvalid` and `araddr` held stable throughout; `inst_data_ok` at T+9; no second `inst_addr_ok` before then.
- `inst_cancel` pulsed while in R, then `rvalid`: no `inst_data_ok`, `inst_rdata` unchanged. A request 0xBFC00380 issued at the next IDLE returns its data normally.
- `rresp` = 2'b10 (SLVERR), `rdata` = 0xDEADBEEF: `inst_data_ok` = 1 and `inst_bus_err` = 1 in the same cycle, `inst_rdata` = 0xDEADBEEF.
- `cpu_rst_n` driven low while in AR: `arvalid` = 0 immediately, state IDLE after release, and the first new request behaves as in the first scenario.

Source files
------------

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared encodings for the instruction-fetch AXI read bridge.
// FSM states and the fixed AXI4 attribute constants used for single-word fetches.
package inst_axi_rd_bridge_pkg;

  typedef enum logic [1:0] {
    IRD_IDLE = 2'd0,
    IRD_AR   = 2'd1,
    IRD_R    = 2'd2
  } ird_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like handshake to single-beat AXI4 read; one outstanding, 3-cycle minimum req-to-data.
// Backpressure: inst_addr_ok only in IDLE outside the data_ok cycle; AXI stalls add one cycle each.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_bus_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  ird_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              data_ok_q;
  logic              bus_err_q;
  logic              cancelled_q;
  logic              drop_resp;

  // Single outstanding, single beat: rid/rlast carry no information here.
  logic unused_r_side;
  assign unused_r_side = ^{rid, rlast};

  assign inst_addr_ok = inst_req & cpu_rst_n & (state_q == IRD_IDLE) & ~data_ok_q;
  // A cancel arriving in the same cycle as rvalid still suppresses the response.
  assign drop_resp    = cancelled_q | inst_cancel;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= IRD_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      data_ok_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cancelled_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IRD_IDLE: begin
          if (inst_addr_ok) begin
            addr_q      <= inst_addr;
            arvalid_q   <= 1'b1;
            cancelled_q <= inst_cancel;
            state_q     <= IRD_AR;
          end
        end
        IRD_AR: begin
          if (inst_cancel) cancelled_q <= 1'b1;
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= IRD_R;
          end
        end
        IRD_R: begin
          if (inst_cancel) cancelled_q <= 1'b1;
          if (rvalid) begin
            rready_q    <= 1'b0;
            cancelled_q <= 1'b0;
            state_q     <= IRD_IDLE;
            if (!drop_resp) begin
              rdata_q   <= rdata;
              data_ok_q <= 1'b1;
              bus_err_q <= (rresp != AXI_RESP_OKAY);
            end
          end
        end
        default: begin
          state_q   <= IRD_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inst_data_ok = data_ok_q;
  assign inst_bus_err = bus_err_q;
  assign inst_rdata   = rdata_q;
  assign arid         = AXI_ID;
  assign araddr       = addr_q;
  assign arlen        = 8'd0;
  assign arsize       = AXI_SIZE_4B;
  assign arburst      = AXI_BURST_INCR;
  assign arvalid      = arvalid_q;
  assign rready       = rready_q;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: bench drives the AXI slave side cycle by cycle.
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  inst_axi_rd_bridge dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .inst_bus_err(inst_bus_err),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Zero-stall fetch, then probe the back-to-back acceptance window.
  task automatic run_basic(input logic [31:0] a, input logic [31:0] d);
    inst_addr = a; inst_req = 1'b1; arready = 1'b1; settle();
    chk("basic_addr_ok_T", inst_addr_ok, 1);
    cyc(); inst_req = 1'b0; settle();
    chk("basic_arvalid_T1", arvalid, 1);
    chk("basic_araddr_T1", araddr, a);
    chk("basic_addr_ok_T1", inst_addr_ok, 0);
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = d; rresp = 2'b00; settle();
    chk("basic_rready_T2", rready, 1);
    chk("basic_arvalid_T2", arvalid, 0);
    cyc(); rvalid = 1'b0; inst_req = 1'b1; settle();
    chk("basic_data_ok_T3", inst_data_ok, 1);
    chk("basic_rdata_T3", inst_rdata, d);
    chk("basic_bus_err_T3", inst_bus_err, 0);
    chk("basic_addr_ok_blocked_T3", inst_addr_ok, 0);
    cyc(); settle();
    chk("basic_data_ok_T4", inst_data_ok, 0);
    chk("basic_addr_ok_T4", inst_addr_ok, 1);
    inst_req = 1'b0;
    cyc(); settle();
    chk("basic_no_issue_after_drop", arvalid, 0);
  endtask

  initial begin
    rst_n = 1'b0; inst_req = 1'b1; inst_addr = 32'h0; inst_cancel = 1'b0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    #12;
    chk("rst_addr_ok", inst_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_data_ok", inst_data_ok, 0);
    chk("rst_bus_err", inst_bus_err, 0);
    chk("rst_rdata", inst_rdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("const_arlen", arlen, 0);
    chk("const_arsize", arsize, 3'b010);
    chk("const_arburst", arburst, 2'b01);
    chk("const_arid", arid, 0);
    inst_req = 1'b0;
    #1 rst_n = 1'b1;
    cyc();

    // Scenario 1: immediate slave
    run_basic(32'hBFC00000, 32'h3C080001);

    // Scenario 2: arready after 4 stall cycles, rvalid after 2 more
    inst_addr = 32'hBFC00010; inst_req = 1'b1; settle();
    chk("stall_addr_ok_T", inst_addr_ok, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(); inst_addr = 32'h0; settle();
      chk("stall_no_addr_ok", inst_addr_ok, 0);
      chk("stall_no_data_ok", inst_data_ok, 0);
      if (i <= 5) begin
        chk("stall_arvalid", arvalid, 1);
        chk("stall_araddr", araddr, 32'hBFC00010);
      end
      arready = (i == 5);
      rvalid  = (i == 8);
      rdata   = 32'h24020005;
    end
    cyc(); arready = 1'b0; rvalid = 1'b0; settle();
    chk("stall_data_ok_T9", inst_data_ok, 1);
    chk("stall_rdata_T9", inst_rdata, 32'h24020005);
    chk("stall_addr_ok_T9", inst_addr_ok, 0);
    inst_req = 1'b0;
    cyc();

    // Scenario 3: cancel while in R
    inst_addr = 32'hBFC00100; inst_req = 1'b1; arready = 1'b1; settle();
    cyc(); inst_req = 1'b0; settle();
    cyc(); arready = 1'b0; inst_cancel = 1'b1; settle();
    chk("cancel_in_r", rready, 1);
    cyc(); inst_cancel = 1'b0; rvalid = 1'b1; rdata = 32'h11111111; settle();
    cyc(); rvalid = 1'b0; settle();
    chk("cancel_no_data_ok", inst_data_ok, 0);
    chk("cancel_rdata_held", inst_rdata, 32'h24020005);
    chk("cancel_rready_low", rready, 0);
    run_basic(32'hBFC00380, 32'h8C010000);

    // Cancel coinciding with acceptance
    inst_addr = 32'hBFC00400; inst_req = 1'b1; inst_cancel = 1'b1; arready = 1'b1; settle();
    cyc(); inst_req = 1'b0; inst_cancel = 1'b0; settle();
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h22222222; settle();
    cyc(); rvalid = 1'b0; settle();
    chk("accept_cancel_no_data_ok", inst_data_ok, 0);
    chk("accept_cancel_rdata_held", inst_rdata, 32'h8C010000);
    cyc();

    // Scenario 4: SLVERR
    inst_addr = 32'hBFC00500; inst_req = 1'b1; arready = 1'b1; settle();
    cyc(); inst_req = 1'b0; settle();
    cyc(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b10; settle();
    cyc(); rvalid = 1'b0; rresp = 2'b00; settle();
    chk("err_data_ok", inst_data_ok, 1);
    chk("err_bus_err", inst_bus_err, 1);
    chk("err_rdata", inst_rdata, 32'hDEADBEEF);
    cyc(); settle();
    chk("err_bus_err_pulse", inst_bus_err, 0);

    // Scenario 5: reset while in AR
    inst_addr = 32'hBFC00600; inst_req = 1'b1; settle();
    cyc(); inst_req = 1'b0; settle();
    chk("rst_mid_arvalid_before", arvalid, 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_arvalid_drop", arvalid, 0);
    chk("rst_mid_araddr", araddr, 0);
    cyc(); #2 rst_n = 1'b1;
    cyc(); settle();
    chk("rst_mid_idle_arvalid", arvalid, 0);
    chk("rst_mid_idle_rready", rready, 0);
    run_basic(32'hBFC00000, 32'h3C080001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
